// File: rtl/sigmoid_lut_rom_if.sv
// sigmoid_lut_rom_if
//   Lookup bus between an activation stage and the sigmoid ROM.
//   addr : signed Q4.4 pre-activation, driven by the requester (master)
//   data : Q4.12 sigmoid value, driven by the ROM (slave), valid one clock
//          after the addr it belongs to was sampled
interface sigmoid_lut_rom_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] data;

   modport master (output addr, input  data);
   modport slave  (input  addr, output data);
endinterface

// File: rtl/sigmoid_lut_rom.sv
// sigmoid_lut_rom
//   Registered 256-entry sigmoid lookup. addr is a two's-complement Q4.4
//   value x = $signed(addr)/16; data is round(4096*sigmoid(x)) in Q4.12.
//   Only the non-negative half (128 entries) is stored. Negative inputs use
//   sigmoid(-x) = 1 - sigmoid(x), so data(-m) = 4096 - P[m].
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset, clears data to 0
//     bus  : slave side of sigmoid_lut_rom_if (addr in, data out)
//   Latency is one clock, a new lookup is accepted every cycle.
//   Only DATA_WIDTH=16, ADDR_WIDTH=8, FRAC_BITS=12 are supported.
module sigmoid_lut_rom #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int FRAC_BITS  = 12
) (
   input  logic               clk,
   input  logic               rst,
   sigmoid_lut_rom_if.slave   bus
);

   localparam int HALF = 2 ** (ADDR_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] ONE_Q = DATA_WIDTH'(1 << FRAC_BITS);

   // P[k] = round-half-up(4096 / (1 + exp(-k/16))), k = 0..127
   localparam logic [FRAC_BITS-1:0] P_ROM [HALF] = '{
      12'd2048, 12'd2112, 12'd2176, 12'd2239, 12'd2303, 12'd2365, 12'd2428, 12'd2489,
      12'd2550, 12'd2609, 12'd2668, 12'd2726, 12'd2782, 12'd2837, 12'd2891, 12'd2943,
      12'd2994, 12'd3044, 12'd3092, 12'd3139, 12'd3184, 12'd3227, 12'd3269, 12'd3310,
      12'd3349, 12'd3386, 12'd3422, 12'd3457, 12'd3490, 12'd3521, 12'd3551, 12'd3580,
      12'd3608, 12'd3634, 12'd3659, 12'd3683, 12'd3705, 12'd3727, 12'd3747, 12'd3767,
      12'd3785, 12'd3803, 12'd3819, 12'd3835, 12'd3850, 12'd3864, 12'd3877, 12'd3890,
      12'd3902, 12'd3913, 12'd3924, 12'd3934, 12'd3943, 12'd3952, 12'd3960, 12'd3968,
      12'd3976, 12'd3983, 12'd3990, 12'd3996, 12'd4002, 12'd4007, 12'd4013, 12'd4018,
      12'd4022, 12'd4027, 12'd4031, 12'd4035, 12'd4038, 12'd4042, 12'd4045, 12'd4048,
      12'd4051, 12'd4054, 12'd4056, 12'd4059, 12'd4061, 12'd4063, 12'd4065, 12'd4067,
      12'd4069, 12'd4070, 12'd4072, 12'd4073, 12'd4075, 12'd4076, 12'd4077, 12'd4078,
      12'd4079, 12'd4080, 12'd4081, 12'd4082, 12'd4083, 12'd4084, 12'd4085, 12'd4085,
      12'd4086, 12'd4086, 12'd4087, 12'd4088, 12'd4088, 12'd4089, 12'd4089, 12'd4089,
      12'd4090, 12'd4090, 12'd4091, 12'd4091, 12'd4091, 12'd4091, 12'd4092, 12'd4092,
      12'd4092, 12'd4092, 12'd4093, 12'd4093, 12'd4093, 12'd4093, 12'd4093, 12'd4094,
      12'd4094, 12'd4094, 12'd4094, 12'd4094, 12'd4094, 12'd4094, 12'd4094, 12'd4095
   };

   logic                  neg;
   logic [ADDR_WIDTH-1:0] mag;
   logic [ADDR_WIDTH-2:0] idx;
   logic [DATA_WIDTH-1:0] pos_val;
   logic [DATA_WIDTH-1:0] data_d;
   logic [DATA_WIDTH-1:0] data_q;

   always_comb begin
      neg     = bus.addr[ADDR_WIDTH-1];
      mag     = neg ? (~bus.addr + 1'b1) : bus.addr;
      idx     = mag[ADDR_WIDTH-2:0];
      pos_val = DATA_WIDTH'(P_ROM[idx]);
      data_d  = pos_val;
      if (neg) begin
         // Magnitude 128 (addr 8'h80) falls outside the stored half; its
         // mirror entry round(4096*sigmoid(8.0)) is 4095, giving 1.
         if (mag[ADDR_WIDTH-1]) data_d = DATA_WIDTH'(1);
         else                   data_d = ONE_Q - pos_val;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) data_q <= '0;
      else     data_q <= data_d;
   end

   assign bus.data = data_q;

endmodule

// File: tb/tb_sigmoid_lut_rom.sv
module tb_sigmoid_lut_rom;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sigmoid_lut_rom_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus_if ();

   sigmoid_lut_rom #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .FRAC_BITS(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] exp_data;
   } vec_t;

   int errors = 0;
   int checks = 0;

   // round-half-up(4096 * sigmoid(m/16)) for m >= 0
   function automatic int sig_q12(int m);
      real s;
      s = 4096.0 / (1.0 + $exp(-real'(m) / 16.0));
      return int'($floor(s + 0.5));
   endfunction

   // Negative inputs mirror the positive curve; m = 128 gives 4096 - 4095 = 1.
   function automatic int model(logic [7:0] a);
      int v;
      v = int'($signed(a));
      if (v >= 0) return sig_q12(v);
      return 4096 - sig_q12(-v);
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input int exp_v);
      checks++;
      if (act !== 16'(exp_v)) begin
         errors++;
         $display("FAIL %s: got %0d (0x%h) expected %0d", name, act, act, exp_v);
      end
   endtask

   // one clock: inputs already applied, sample output 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t        vecs[$];
   logic [15:0] got [256];
   logic [7:0]  ra;
   logic        rr;

   initial begin
      vecs.push_back('{8'h00, 16'd2048});
      vecs.push_back('{8'h08, 16'd2550});
      vecs.push_back('{8'h10, 16'd2994});
      vecs.push_back('{8'h7F, 16'd4095});
      vecs.push_back('{8'hF0, 16'd1102});
      vecs.push_back('{8'hF8, 16'd1546});
      vecs.push_back('{8'h80, 16'd1});
      vecs.push_back('{8'h01, 16'd2112});
      vecs.push_back('{8'hFF, 16'd1984});
      vecs.push_back('{8'h40, 16'd4022});
      vecs.push_back('{8'hC0, 16'd74});
      vecs.push_back('{8'h81, 16'd1});

      // reset held two cycles with a live address
      rst = 1'b1;
      bus_if.addr = 8'h10;
      step();
      chk("reset_c1", bus_if.data, 0);
      step();
      chk("reset_c2", bus_if.data, 0);
      rst = 1'b0;
      step();
      chk("reset_release", bus_if.data, 2994);

      // fixed vectors
      foreach (vecs[i]) begin
         bus_if.addr = vecs[i].addr;
         step();
         chk($sformatf("vec_%02h", vecs[i].addr), bus_if.data, int'(vecs[i].exp_data));
      end

      // holds value while addr is stable
      bus_if.addr = 8'hF0;
      step();
      step();
      chk("hold", bus_if.data, 1102);

      // back-to-back, no bubbles
      bus_if.addr = 8'h00; step(); chk("b2b_0", bus_if.data, 2048);
      bus_if.addr = 8'h10; step(); chk("b2b_1", bus_if.data, 2994);
      bus_if.addr = 8'hF0; step(); chk("b2b_2", bus_if.data, 1102);

      // full sweep in signed order against the model
      for (int v = -128; v < 128; v++) begin
         bus_if.addr = 8'(v);
         step();
         got[v + 128] = bus_if.data;
         chk($sformatf("sweep_%0d", v), bus_if.data, model(8'(v)));
      end
      for (int a = 1; a < 128; a++)
         chk($sformatf("sym_%0d", a), 16'(got[128 + a] + got[128 - a]), 4096);
      for (int v = -127; v < 128; v++) begin
         checks++;
         if (got[v + 128] < got[v + 127]) begin
            errors++;
            $display("FAIL mono_%0d: got %0d after %0d, required non-decreasing",
                     v, got[v + 128], got[v + 127]);
         end
      end

      // reset asserted mid-stream, then lookup resumes
      bus_if.addr = 8'h20; step(); chk("mid_pre", bus_if.data, 3608);
      rst = 1'b1; bus_if.addr = 8'h30; step(); chk("mid_rst", bus_if.data, 0);
      rst = 1'b0; bus_if.addr = 8'hD0; step(); chk("mid_resume", bus_if.data, 194);
      bus_if.addr = 8'h7F; step(); chk("mid_next", bus_if.data, 4095);

      // random addresses with occasional reset pulses
      for (int n = 0; n < 400; n++) begin
         ra = 8'($urandom);
         rr = ($urandom_range(0, 15) == 0);
         rst = rr;
         bus_if.addr = ra;
         step();
         chk($sformatf("rand_%0d_%02h", n, ra), bus_if.data, rr ? 0 : model(ra));
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
